// File: rtl/prt_dptx_ctl_seq_pkg.sv
// Shared types and constants for the DP TX control-register sequencer.
package prt_dptx_ctl_pkg;

    localparam int unsigned CTL_W = 5;

    // Control register bit positions
    localparam int unsigned CTL_LANES   = 0;
    localparam int unsigned CTL_TRN_SEL = 1;
    localparam int unsigned CTL_VID_EN  = 2;
    localparam int unsigned CTL_EFM     = 3;
    localparam int unsigned CTL_SCRM_EN = 4;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_TRAIN = 2'd1,
        CMD_VIDEO = 2'd2,
        CMD_OFF   = 2'd3
    } cmd_e;

    // Write masks: video enable only, link fields (all but VID_EN), everything
    localparam logic [CTL_W-1:0] MSK_VID  = 5'h04;
    localparam logic [CTL_W-1:0] MSK_LINK = 5'h1B;
    localparam logic [CTL_W-1:0] MSK_ALL  = 5'h1F;

    typedef struct packed {
        logic [CTL_W-1:0] mask;
        logic [CTL_W-1:0] ctl;
        logic             last_step;
    } step_t;

    // Mask/control pair for a command step (step 0 = first, 1 = second)
    function automatic step_t step_f(cmd_e cmd, logic step, logic lanes, logic efm);
        step_t            d;
        logic [CTL_W-1:0] link;
        d                = '0;
        link             = '0;
        link[CTL_LANES]  = lanes;
        link[CTL_EFM]    = efm;
        case (cmd)
            CMD_TRAIN: begin
                if (!step) begin
                    d.mask = MSK_VID;
                    d.ctl  = '0;
                end else begin
                    d.mask             = MSK_LINK;
                    d.ctl              = link;
                    d.ctl[CTL_TRN_SEL] = 1'b1;
                    d.last_step        = 1'b1;
                end
            end
            CMD_VIDEO: begin
                if (!step) begin
                    d.mask             = MSK_LINK;
                    d.ctl              = link;
                    d.ctl[CTL_SCRM_EN] = 1'b1;
                end else begin
                    d.mask            = MSK_VID;
                    d.ctl             = '0;
                    d.ctl[CTL_VID_EN] = 1'b1;
                    d.last_step       = 1'b1;
                end
            end
            CMD_OFF: begin
                d.mask      = MSK_ALL;
                d.ctl       = '0;
                d.last_step = 1'b1;
            end
            default: begin
                d.last_step = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/prt_dptx_ctl_seq_if.sv
// Policy command port and TX message bus of the control sequencer.
interface prt_dptx_ctl_seq_if #(
    parameter int unsigned P_MSG_DAT = 16
);
    logic [1:0]           CMD_IN;
    logic                 CMD_VLD_IN;
    logic                 CMD_RDY_OUT;
    logic                 CFG_LANES_IN;
    logic                 CFG_EFM_IN;
    logic                 MSG_SOM_OUT;
    logic                 MSG_EOM_OUT;
    logic [P_MSG_DAT-1:0] MSG_DAT_OUT;
    logic                 MSG_VLD_OUT;
    logic                 MSG_RDY_IN;

    // Sequencer side
    modport master (
        input  CMD_IN, CMD_VLD_IN, CFG_LANES_IN, CFG_EFM_IN, MSG_RDY_IN,
        output CMD_RDY_OUT, MSG_SOM_OUT, MSG_EOM_OUT, MSG_DAT_OUT, MSG_VLD_OUT
    );

    // Policy processor / message consumer side
    modport slave (
        output CMD_IN, CMD_VLD_IN, CFG_LANES_IN, CFG_EFM_IN, MSG_RDY_IN,
        input  CMD_RDY_OUT, MSG_SOM_OUT, MSG_EOM_OUT, MSG_DAT_OUT, MSG_VLD_OUT
    );
endinterface

// File: rtl/prt_dptx_ctl_seq.sv
// Turns TRAIN/VIDEO/OFF link commands into ordered mask+control message writes.
module prt_dptx_ctl_seq
    import prt_dptx_ctl_pkg::*;
#(
    parameter int unsigned P_MSG_IDX = 5,
    parameter int unsigned P_MSG_DAT = 16,
    parameter int unsigned P_MSG_ID  = 0,
    parameter int unsigned P_WAIT    = 64
) (
    input  logic                 RST_IN,
    input  logic                 CLK_IN,
    prt_dptx_ctl_seq_if.master   bus,
    output logic [CTL_W-1:0]     STA_CTL_OUT,
    output logic                 BUSY_OUT
);

    localparam int unsigned          CNT_W     = $clog2(P_WAIT + 1);
    localparam logic [CNT_W-1:0]     WAIT_LOAD = CNT_W'(P_WAIT - 1);
    localparam logic [P_MSG_DAT-1:0] HDR_WORD  = P_MSG_DAT'(8'(P_MSG_ID));

    // Reject parameter sets the datapath cannot represent
    if (P_WAIT < 1 || P_MSG_DAT < 8 || P_MSG_IDX < 1) begin : g_param_chk
        $error("prt_dptx_ctl_seq: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_MSK  = 3'd2,
        ST_CTL  = 3'd3,
        ST_WAIT = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 step_q, step_d;
    cmd_e                 cmd_q, cmd_d;
    logic                 lanes_q, lanes_d;
    logic                 efm_q, efm_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CTL_W-1:0]     sta_q, sta_d;
    logic                 vld_q, vld_d;
    logic                 som_q, som_d;
    logic                 eom_q, eom_d;
    logic [P_MSG_DAT-1:0] dat_q, dat_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 msg_acc;
    step_t                desc;

    assign desc    = step_f(cmd_q, step_q, lanes_q, efm_q);
    assign msg_acc = vld_q & bus.MSG_RDY_IN;

    // State and registered outputs
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
            cmd_q   <= CMD_NOP;
            lanes_q <= 1'b0;
            efm_q   <= 1'b0;
            cnt_q   <= '0;
            sta_q   <= '0;
            vld_q   <= 1'b0;
            som_q   <= 1'b0;
            eom_q   <= 1'b0;
            dat_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cmd_q   <= cmd_d;
            lanes_q <= lanes_d;
            efm_q   <= efm_d;
            cnt_q   <= cnt_d;
            sta_q   <= sta_d;
            vld_q   <= vld_d;
            som_q   <= som_d;
            eom_q   <= eom_d;
            dat_q   <= dat_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    // Next state, wait counter, shadow register and message word selection
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cmd_d   = cmd_q;
        lanes_d = lanes_q;
        efm_d   = efm_q;
        cnt_d   = cnt_q;
        sta_d   = sta_q;
        vld_d   = vld_q;
        som_d   = som_q;
        eom_d   = eom_q;
        dat_d   = dat_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.CMD_VLD_IN && rdy_q && (cmd_e'(bus.CMD_IN) != CMD_NOP)) begin
                    cmd_d   = cmd_e'(bus.CMD_IN);
                    lanes_d = bus.CFG_LANES_IN;
                    efm_d   = bus.CFG_EFM_IN;
                    step_d  = 1'b0;
                    state_d = ST_HDR;
                    vld_d   = 1'b1;
                    som_d   = 1'b1;
                    eom_d   = 1'b0;
                    dat_d   = HDR_WORD;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_HDR: begin
                if (msg_acc) begin
                    state_d = ST_MSK;
                    som_d   = 1'b0;
                    dat_d   = P_MSG_DAT'(desc.mask);
                end
            end
            ST_MSK: begin
                if (msg_acc) begin
                    state_d = ST_CTL;
                    eom_d   = 1'b1;
                    dat_d   = P_MSG_DAT'(desc.ctl);
                end
            end
            ST_CTL: begin
                if (msg_acc) begin
                    sta_d = (sta_q & ~desc.mask) | (desc.ctl & desc.mask);
                    vld_d = 1'b0;
                    eom_d = 1'b0;
                    dat_d = '0;
                    if (desc.last_step) begin
                        state_d = ST_IDLE;
                        rdy_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        step_d  = 1'b1;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_HDR;
                    vld_d   = 1'b1;
                    som_d   = 1'b1;
                    dat_d   = HDR_WORD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.CMD_RDY_OUT = rdy_q;
    assign bus.MSG_VLD_OUT = vld_q;
    assign bus.MSG_SOM_OUT = som_q;
    assign bus.MSG_EOM_OUT = eom_q;
    assign bus.MSG_DAT_OUT = dat_q;
    assign STA_CTL_OUT     = sta_q;
    assign BUSY_OUT        = busy_q;

endmodule

// File: tb/tb_prt_dptx_ctl_seq.sv
// Bench for prt_dptx_ctl_seq: queue-based word model plus directed literal checks.
module tb_prt_dptx_ctl_seq;

    localparam int unsigned P_WAIT = 4;
    localparam int unsigned P_DAT  = 16;
    localparam int unsigned P_ID   = 0;

    logic       CLK_IN = 1'b0;
    logic       RST_IN;
    logic [4:0] sta;
    logic       busy;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    prt_dptx_ctl_seq_if #(.P_MSG_DAT(P_DAT)) bus ();

    prt_dptx_ctl_seq #(
        .P_MSG_IDX(5),
        .P_MSG_DAT(P_DAT),
        .P_MSG_ID (P_ID),
        .P_WAIT   (P_WAIT)
    ) dut (
        .RST_IN     (RST_IN),
        .CLK_IN     (CLK_IN),
        .bus        (bus),
        .STA_CTL_OUT(sta),
        .BUSY_OUT   (busy)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out, expected event within bound (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        som;
        logic        eom;
        logic [15:0] dat;
        logic [4:0]  mask;
    } word_t;

    word_t       wq[$];     // words of the step being emitted
    word_t       s2q[$];    // words of the pending second step
    int          m_phase;   // 0 idle, 1 emitting, 2 settle gap
    int          m_wait;
    logic [4:0]  m_sta;
    word_t       mw;
    logic [15:0] log_dat[$];
    int          log_cyc[$];
    logic [15:0] expq[$];

    task automatic add_step(input int which, input logic [4:0] mask, input logic [4:0] ctl);
        word_t h, m, c;
        h = '{som: 1'b1, eom: 1'b0, dat: 16'(P_ID), mask: 5'h00};
        m = '{som: 1'b0, eom: 1'b0, dat: 16'(mask), mask: 5'h00};
        c = '{som: 1'b0, eom: 1'b1, dat: 16'(ctl), mask: mask};
        if (which == 1) begin
            wq.push_back(h); wq.push_back(m); wq.push_back(c);
        end else begin
            s2q.push_back(h); s2q.push_back(m); s2q.push_back(c);
        end
    endtask

    task automatic model_cmd(input int c, input int lanes, input int efm);
        case (c)
            1: begin
                add_step(1, 5'h04, 5'h00);
                add_step(2, 5'h1B, 5'(lanes + 2 + 8 * efm));
            end
            2: begin
                add_step(1, 5'h1B, 5'(lanes + 8 * efm + 16));
                add_step(2, 5'h04, 5'h04);
            end
            3: add_step(1, 5'h1F, 5'h00);
            default: ;
        endcase
        if (c != 0) m_phase = 1;
    endtask

    // Compare DUT against model each cycle, then advance model with the inputs for the next edge
    always @(negedge CLK_IN) begin
        if (RST_IN) begin
            m_phase = 0;
            m_wait  = 0;
            m_sta   = 5'h00;
            wq.delete();
            s2q.delete();
            chk("rst_cmd_rdy", 32'(bus.CMD_RDY_OUT), 32'(1));
            chk("rst_vld", 32'(bus.MSG_VLD_OUT), 32'(0));
            chk("rst_dat", 32'(bus.MSG_DAT_OUT), 32'(0));
            chk("rst_sta", 32'(sta), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
        end else begin
            chk("cmd_rdy", 32'(bus.CMD_RDY_OUT), 32'(m_phase == 0));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("msg_vld", 32'(bus.MSG_VLD_OUT), 32'(m_phase == 1));
            chk("sta_ctl", 32'(sta), 32'(m_sta));
            if (m_phase == 1 && wq.size() > 0) begin
                chk("msg_som", 32'(bus.MSG_SOM_OUT), 32'(wq[0].som));
                chk("msg_eom", 32'(bus.MSG_EOM_OUT), 32'(wq[0].eom));
                chk("msg_dat", 32'(bus.MSG_DAT_OUT), 32'(wq[0].dat));
            end
            if (bus.MSG_VLD_OUT && bus.MSG_RDY_IN) begin
                log_dat.push_back(bus.MSG_DAT_OUT);
                log_cyc.push_back(cyc);
            end
            case (m_phase)
                0: if (bus.CMD_VLD_IN)
                       model_cmd(int'(bus.CMD_IN), int'(bus.CFG_LANES_IN), int'(bus.CFG_EFM_IN));
                1: if (bus.MSG_RDY_IN && wq.size() > 0) begin
                       mw = wq.pop_front();
                       if (mw.eom) m_sta = (m_sta & ~mw.mask) | (mw.dat[4:0] & mw.mask);
                       if (wq.size() == 0) begin
                           if (s2q.size() > 0) begin
                               m_phase = 2;
                               m_wait  = P_WAIT;
                           end else begin
                               m_phase = 0;
                           end
                       end
                   end
                default: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        wq = s2q;
                        s2q.delete();
                        m_phase = 1;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_cmd(input logic [1:0] c, input logic l, input logic e, output int acc_cyc);
        bit done;
        done = 1'b0;
        bus.CMD_IN       = c;
        bus.CFG_LANES_IN = l;
        bus.CFG_EFM_IN   = e;
        bus.CMD_VLD_IN   = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK_IN);
            if (bus.CMD_RDY_OUT) done = 1'b1;
            @(posedge CLK_IN);
        end
        #1;
        bus.CMD_VLD_IN = 1'b0;
        acc_cyc = cyc;
        if (!done) timeout_fail("cmd_accept");
    endtask

    task automatic wait_idle(output int rdy_cyc);
        bit done;
        done    = 1'b0;
        rdy_cyc = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK_IN);
            if (bus.CMD_RDY_OUT) begin
                done    = 1'b1;
                rdy_cyc = cyc;
            end
        end
        @(posedge CLK_IN);
        #1;
        if (!done) timeout_fail("wait_idle");
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 200 && log_dat.size() < n; i++) @(posedge CLK_IN);
        #1;
        if (log_dat.size() < n) timeout_fail("wait_words");
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, 32'(log_dat.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < log_dat.size(); i++)
            chk($sformatf("%s_word%0d", name, i), 32'(log_dat[i]), 32'(expq[i]));
    endtask

    task automatic clr_log();
        log_dat.delete();
        log_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int a1, a2, c1;
        RST_IN           = 1'b1;
        bus.CMD_IN       = 2'd0;
        bus.CMD_VLD_IN   = 1'b0;
        bus.CFG_LANES_IN = 1'b0;
        bus.CFG_EFM_IN   = 1'b0;
        bus.MSG_RDY_IN   = 1'b1;
        repeat (3) @(posedge CLK_IN);
        #1;
        chk("reset_rdy", 32'(bus.CMD_RDY_OUT), 32'(1));
        chk("reset_vld", 32'(bus.MSG_VLD_OUT), 32'(0));
        chk("reset_sta", 32'(sta), 32'(0));
        RST_IN = 1'b0;
        @(posedge CLK_IN);
        #1;

        // TRAIN, 4 lanes, enhanced framing
        clr_log();
        do_cmd(2'd1, 1'b1, 1'b1, a1);
        wait_idle(c1);
        chk("train_rdy_latency", 32'(c1 - a1 + 1), 32'(11));
        expq = '{16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h001B, 16'h000B};
        chk_log("train");
        if (log_cyc.size() >= 4) chk("train_gap", 32'(log_cyc[3] - log_cyc[2]), 32'(5));
        chk("train_sta", 32'(sta), 32'h0B);

        // VIDEO, 2 lanes, enhanced framing
        clr_log();
        do_cmd(2'd2, 1'b0, 1'b1, a1);
        wait_words(3);
        chk("video_step1_sta", 32'(sta), 32'h18);
        wait_idle(c1);
        expq = '{16'h0000, 16'h001B, 16'h0018, 16'h0000, 16'h0004, 16'h0004};
        chk_log("video");
        chk("video_sta", 32'(sta), 32'h1C);

        // OFF with downstream stalling every other cycle
        clr_log();
        do_cmd(2'd3, 1'b0, 1'b0, a1);
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK_IN);
            #1;
            bus.MSG_RDY_IN = ~bus.MSG_RDY_IN;
        end
        bus.MSG_RDY_IN = 1'b1;
        wait_idle(c1);
        expq = '{16'h0000, 16'h001F, 16'h0000};
        chk_log("off_stall");
        if (log_cyc.size() >= 3) chk("off_stall_spacing", 32'(log_cyc[2] - log_cyc[0]), 32'(4));
        chk("off_sta", 32'(sta), 32'h00);

        // NOP
        clr_log();
        do_cmd(2'd0, 1'b0, 1'b0, a1);
        chk("nop_rdy", 32'(bus.CMD_RDY_OUT), 32'(1));
        chk("nop_vld", 32'(bus.MSG_VLD_OUT), 32'(0));
        repeat (3) @(posedge CLK_IN);
        #1;
        chk("nop_words", 32'(log_dat.size()), 32'(0));

        // Command held valid across a TRAIN
        clr_log();
        do_cmd(2'd1, 1'b1, 1'b0, a1);
        do_cmd(2'd2, 1'b1, 1'b0, a2);
        chk("held_accept_gap", 32'(a2 - a1), 32'(11));
        chk("held_next_vld", 32'(bus.MSG_VLD_OUT), 32'(1));
        chk("held_next_som", 32'(bus.MSG_SOM_OUT), 32'(1));
        wait_idle(c1);
        chk("held_words", 32'(log_dat.size()), 32'(12));
        chk("held_sta", 32'(sta), 32'h15);

        // Reset during the settle gap of a VIDEO
        clr_log();
        do_cmd(2'd2, 1'b0, 1'b0, a1);
        wait_words(3);
        @(posedge CLK_IN);
        #1;
        chk("pre_rst_sta", 32'(sta), 32'h14);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        #2;
        RST_IN = 1'b1;
        #1;
        chk("async_rst_rdy", 32'(bus.CMD_RDY_OUT), 32'(1));
        chk("async_rst_vld", 32'(bus.MSG_VLD_OUT), 32'(0));
        chk("async_rst_som", 32'(bus.MSG_SOM_OUT), 32'(0));
        chk("async_rst_eom", 32'(bus.MSG_EOM_OUT), 32'(0));
        chk("async_rst_dat", 32'(bus.MSG_DAT_OUT), 32'(0));
        chk("async_rst_sta", 32'(sta), 32'(0));
        chk("async_rst_busy", 32'(busy), 32'(0));
        repeat (2) @(posedge CLK_IN);
        #1;
        RST_IN = 1'b0;
        clr_log();
        do_cmd(2'd3, 1'b1, 1'b1, a1);
        wait_idle(c1);
        chk("post_rst_off_latency", 32'(c1 - a1 + 1), 32'(4));
        expq = '{16'h0000, 16'h001F, 16'h0000};
        chk_log("post_rst_off");
        chk("post_rst_sta", 32'(sta), 32'h00);

        repeat (2) @(posedge CLK_IN);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prt_dptx_ctl_seq.md
# prt_dptx_ctl_seq

Command-driven sequencer for the DP TX control register block. It turns high-level link commands from the policy processor (TRAIN, VIDEO, OFF) into ordered message writes of mask (index 0) and control (index 1) words, with a programmable settle gap between dependent steps. It sits between the policy command port and the TX message bus, upstream of the control-register slave.

## Interface
- P_MSG_IDX, 5, message index width (kept for bus compatibility)
- P_MSG_DAT, 16, message data width
- P_MSG_ID, 0, ID of the target control-register slave, placed in the header word
- P_WAIT, 64, settle cycles between step 1 and step 2; must be ≥1
- RST_IN  in  1  reset, asynchronous, active-high
- CLK_IN  in  1  clock
- CMD_IN  in  2  command: 0 NOP, 1 TRAIN, 2 VIDEO, 3 OFF
- CMD_VLD_IN  in  1  command valid
- CMD_RDY_OUT  out  1  command ready; high only in IDLE
- CFG_LANES_IN  in  1  lane select (0 = 2 lanes, 1 = 4 lanes); sampled at command accept
- CFG_EFM_IN  in  1  enhanced framing; sampled at command accept
- MSG_SOM_OUT  out  1  first word of message (header)
- MSG_EOM_OUT  out  1  last word of message (control word)
- MSG_DAT_OUT  out  P_MSG_DAT  message word
- MSG_VLD_OUT  out  1  word valid
- MSG_RDY_IN  in  1  downstream accepts word
- STA_CTL_OUT  out  5  shadow of the slave control register after the last accepted control word
- BUSY_OUT  out  1  high in any state except IDLE

## Operation
- Control bit positions: 0 LANES, 1 TRN_SEL, 2 VID_EN, 3 EFM, 4 SCRM_EN.
- Message = 3 words: header (P_MSG_ID in bits [7:0], rest 0, SOM=1), mask word (bits [4:0], rest 0), control word (bits [4:0], rest 0, EOM=1).
- Command accept: CMD_VLD_IN & CMD_RDY_OUT. Latch CMD, CFG_LANES_IN and CFG_EFM_IN.
- NOP: accepted, no message, stays in IDLE.
- TRAIN: step 1 mask 0x04, ctl 0x00 (video off); wait; step 2 mask 0x1B, ctl = {scrm 0, efm, trn_sel 1, lanes}.
- VIDEO: step 1 mask 0x1B, ctl = {scrm 1, efm, trn_sel 0, lanes}; wait; step 2 mask 0x04, ctl 0x04.
- OFF: single step, mask 0x1F, ctl 0x00; no wait.
- FSM: IDLE -> HDR -> MSK -> CTL -> (WAIT -> HDR -> MSK -> CTL) -> IDLE. A word state advances only on MSG_VLD_OUT & MSG_RDY_IN.
- STA_CTL_OUT update on control-word accept: sta = (sta & ~mask) | (ctl & mask).
- CMD_IN values arriving while busy are not sampled; the requester holds CMD_VLD_IN until accepted.

## Timing
- Reset values: CMD_RDY_OUT 1, MSG_VLD_OUT 0, MSG_SOM_OUT 0, MSG_EOM_OUT 0, MSG_DAT_OUT 0, STA_CTL_OUT 0, BUSY_OUT 0, FSM IDLE, wait counter 0.
- Command accepted in cycle T: the header is valid at T+1 and CMD_RDY_OUT is low from T+1.
- MSG outputs are registered and held stable while MSG_VLD_OUT & !MSG_RDY_IN. MSG_VLD_OUT is never deasserted before acceptance, except by reset.
- With MSG_RDY_IN held at 1: step 1 words at T+1..T+3, WAIT for exactly P_WAIT cycles (T+4..T+3+P_WAIT), step 2 words at T+4+P_WAIT..T+6+P_WAIT, and CMD_RDY_OUT high at T+7+P_WAIT.
- OFF or single step: CMD_RDY_OUT is high at T+4.
- The wait counter is loaded with P_WAIT-1 on step-1 control-word accept and decrements to 0. It is P_WAIT-bit safe via $clog2(P_WAIT+1).
- Back-to-back: a command can be accepted in the first IDLE cycle.
- Reset mid-message: outputs drop immediately to reset values. The partial message is abandoned, and STA_CTL_OUT goes to 0, which matches the slave's own reset.

## Structure
- prt_dptx_ctl_pkg holds:
  - control bit position constants
  - command code enum
  - mask constants 0x04, 0x1B, 0x1F
  - step-descriptor typedef {mask, ctl, last_step}
  - function step_f(cmd, step, lanes, efm) returning the descriptor
- No sub-module; the FSM, wait counter and shadow register live in one file.

## Test plan
- TRAIN, lanes=1, efm=1, RDY=1, P_WAIT=4: words 0x0000/0x0004/0x0000, 4 idle cycles, then 0x0000/0x001B/0x000B; STA_CTL_OUT=0x0B; CMD_RDY_OUT high 11 cycles after accept.
- VIDEO after TRAIN, lanes=0, efm=1: step 1 ctl 0x18 (STA=0x18), step 2 ctl 0x04 -> STA_CTL_OUT=0x1C.
- OFF with MSG_RDY_IN toggled 1-0-1 per cycle: each word is held stable across the stall cycles, 3 words total, STA_CTL_OUT=0x00.
- NOP: accepted in one cycle, MSG_VLD_OUT stays 0, CMD_RDY_OUT stays 1.
- CMD_VLD_IN held during a TRAIN: the second command is not accepted until CMD_RDY_OUT returns, then it starts the next cycle.
- RST_IN asserted during the WAIT of a VIDEO: all outputs reach reset values asynchronously; after release a new OFF runs normally.
